// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared flit layout and default router parameters
package router_pkg;
    localparam int NUM_PORTS_DEF = 4;
    localparam int NUM_VCS_DEF   = 2;
    localparam int BUF_DEPTH_DEF = 4;
    localparam int FLIT_W_DEF    = 32;
    localparam int ROUTE_W       = $clog2(NUM_PORTS_DEF);

    typedef struct packed {
        logic               head;
        logic               tail;
        logic [ROUTE_W-1:0] route;
        logic [FLIT_W_DEF-1:0] payload;
    } flit_t;

    localparam int FLIT_BITS = $bits(flit_t);
    localparam int HEAD_BIT  = FLIT_BITS - 1;
    localparam int TAIL_BIT  = FLIT_BITS - 2;

    typedef enum logic {
        VC_IDLE   = 1'b0,
        VC_ACTIVE = 1'b1
    } vc_state_t;
endpackage

// File: rtl/arbiter_round_robin.sv
// rtl/arbiter_round_robin.sv - round-robin one-hot picker whose pointer moves only when a grant is used
module arbiter_round_robin #(
    parameter int NUM_REQS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req,
    input  logic                advance,
    output logic [NUM_REQS-1:0] grant
);
    localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        sel   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQS);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        if (found) begin
            grant[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (int'(sel) == NUM_REQS - 1) ? '0 : sel + 1'b1;
        end
    end
endmodule

// File: rtl/sa_requester.sv
// rtl/sa_requester.sv - per-input-port VC buffering and switch-allocation requester
module sa_requester
    import router_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int NUM_VCS   = NUM_VCS_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF,
    parameter int FLIT_W    = FLIT_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [$clog2(NUM_VCS)-1:0]   in_vc,
    input  flit_t                        in_flit,
    output logic [NUM_PORTS-1:0]         requests,
    input  logic [NUM_PORTS-1:0]         grants,
    output logic                         out_valid,
    output flit_t                        out_flit,
    output logic [$clog2(NUM_PORTS)-1:0] out_port,
    output logic                         credit_out_valid,
    output logic [$clog2(NUM_VCS)-1:0]   credit_out_vc,
    input  logic [NUM_PORTS-1:0]         credit_in,
    output logic                         overflow_err
);
    localparam int VC_W   = $clog2(NUM_VCS);
    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W  = $clog2(BUF_DEPTH + 1);

    // flit_t is fixed by the package, so the payload and route widths must agree with it
    if (FLIT_W != FLIT_W_DEF || PORT_W > ROUTE_W) begin : g_cfg_check
        $error("sa_requester: FLIT_W/NUM_PORTS do not match router_pkg flit_t");
    end

    flit_t            mem        [NUM_VCS][BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr     [NUM_VCS];
    logic [PTR_W-1:0] wr_ptr     [NUM_VCS];
    logic [CNT_W-1:0] count      [NUM_VCS];
    vc_state_t        state      [NUM_VCS];
    vc_state_t        state_next [NUM_VCS];
    logic [PORT_W-1:0] vc_port   [NUM_VCS];
    logic [CNT_W-1:0] credit     [NUM_PORTS];

    logic [NUM_VCS-1:0] port_req [NUM_PORTS];
    logic [NUM_VCS-1:0] port_gnt [NUM_PORTS];
    logic [NUM_PORTS-1:0] port_adv;
    logic [NUM_VCS-1:0] wr;
    logic [NUM_VCS-1:0] deq;
    logic [NUM_VCS-1:0] front_head;
    logic [PORT_W-1:0]  front_route [NUM_VCS];
    logic [PORT_W-1:0]  gport;
    logic               grant_ok;
    logic [VC_W-1:0]    deq_vc;
    flit_t              deq_flit;
    logic               overflow_hit;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (int'(ptr) == BUF_DEPTH - 1) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_req[p] = '0;
            for (int v = 0; v < NUM_VCS; v++) begin
                port_req[p][v] = (state[v] == VC_ACTIVE) && (count[v] != '0) &&
                                 (vc_port[v] == PORT_W'(p));
            end
            requests[p] = (|port_req[p]) && (credit[p] != '0);
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_arb
        arbiter_round_robin #(.NUM_REQS(NUM_VCS)) u_arb (
            .clk     (clk),
            .reset   (reset),
            .req     (port_req[p]),
            .advance (port_adv[p]),
            .grant   (port_gnt[p])
        );
    end

    // Only the lowest asserted grant bit counts, and only if that port is actually requested
    always_comb begin
        gport = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (grants[p]) begin
                gport = PORT_W'(p);
            end
        end
        grant_ok = (|grants) && requests[gport];
        port_adv = '0;
        deq      = '0;
        if (grant_ok) begin
            port_adv[gport] = 1'b1;
            deq             = port_gnt[gport];
        end
        deq_vc = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (deq[v]) begin
                deq_vc = VC_W'(v);
            end
        end
        deq_flit = mem[deq_vc][rd_ptr[deq_vc]];
    end

    // An empty idle VC looks at the flit being written so a head can request next cycle
    always_comb begin
        overflow_hit = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            wr[v] = in_valid && (in_vc == VC_W'(v)) &&
                    ((count[v] != CNT_W'(BUF_DEPTH)) || deq[v]);
            if (in_valid && (in_vc == VC_W'(v)) && !wr[v]) begin
                overflow_hit = 1'b1;
            end
            if (count[v] == '0) begin
                front_head[v]  = wr[v] && in_flit[HEAD_BIT];
                front_route[v] = PORT_W'(in_flit.route);
            end else begin
                front_head[v]  = mem[v][rd_ptr[v]][HEAD_BIT];
                front_route[v] = PORT_W'(mem[v][rd_ptr[v]].route);
            end
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            state_next[v] = state[v];
            case (state[v])
                VC_IDLE:   if (front_head[v]) state_next[v] = VC_ACTIVE;
                VC_ACTIVE: if (deq[v] && deq_flit[TAIL_BIT]) state_next[v] = VC_IDLE;
                default:   state_next[v] = VC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VCS; v++) begin
            state[v] <= reset ? VC_IDLE : state_next[v];
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VCS; v++) begin
            if (wr[v]) begin
                mem[v][wr_ptr[v]] <= in_flit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                rd_ptr[v]  <= '0;
                wr_ptr[v]  <= '0;
                count[v]   <= '0;
                vc_port[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (state[v] == VC_IDLE && front_head[v]) begin
                    vc_port[v] <= front_route[v];
                end
                if (wr[v]) begin
                    wr_ptr[v] <= ptr_inc(wr_ptr[v]);
                end
                if (deq[v]) begin
                    rd_ptr[v] <= ptr_inc(rd_ptr[v]);
                end
                if (wr[v] && !deq[v]) begin
                    count[v] <= count[v] + 1'b1;
                end else if (!wr[v] && deq[v]) begin
                    count[v] <= count[v] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid        <= 1'b0;
            out_flit         <= '0;
            out_port         <= '0;
            credit_out_valid <= 1'b0;
            credit_out_vc    <= '0;
            overflow_err     <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                credit[p] <= CNT_W'(BUF_DEPTH);
            end
        end else begin
            out_valid        <= grant_ok;
            credit_out_valid <= grant_ok;
            if (grant_ok) begin
                out_flit      <= deq_flit;
                out_port      <= gport;
                credit_out_vc <= deq_vc;
            end
            if (overflow_hit) begin
                overflow_err <= 1'b1;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (credit_in[p] && !port_adv[p]) begin
                    if (credit[p] != CNT_W'(BUF_DEPTH)) credit[p] <= credit[p] + 1'b1;
                end else if (port_adv[p] && !credit_in[p]) begin
                    if (credit[p] != '0) credit[p] <= credit[p] - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sa_requester.sv
// tb/tb_sa_requester.sv - scenario and randomized checks of sa_requester against a queue-based model
module tb_sa_requester;
    import router_pkg::*;

    localparam int NP = 4;
    localparam int NV = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [0:0]    in_vc;
    flit_t         in_flit;
    logic [NP-1:0] requests;
    logic [NP-1:0] grants;
    logic          out_valid;
    flit_t         out_flit;
    logic [1:0]    out_port;
    logic          credit_out_valid;
    logic [0:0]    credit_out_vc;
    logic [NP-1:0] credit_in;
    logic          overflow_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sa_requester #(.NUM_PORTS(NP), .NUM_VCS(NV), .BUF_DEPTH(DEPTH), .FLIT_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
        .requests(requests), .grants(grants), .out_valid(out_valid), .out_flit(out_flit),
        .out_port(out_port), .credit_out_valid(credit_out_valid), .credit_out_vc(credit_out_vc),
        .credit_in(credit_in), .overflow_err(overflow_err)
    );

    // Reference model: per-VC flit queues, packet-open flags, credit counts, RR pointers
    flit_t mq [NV][$];
    bit    m_active [NV];
    int    m_port [NV];
    int    m_cred [NP];
    int    m_rr [NP];
    bit    m_ovf;
    bit    e_valid;
    flit_t e_flit;
    int    e_port;
    int    e_vc;

    function automatic flit_t mk(bit h, bit t, int r, logic [31:0] pl);
        flit_t f;
        f.head = h; f.tail = t; f.route = 2'(r); f.payload = pl;
        return f;
    endfunction

    function automatic logic [NP-1:0] model_req();
        logic [NP-1:0] r = '0;
        for (int v = 0; v < NV; v++)
            if (m_active[v] && mq[v].size() > 0 && m_cred[m_port[v]] > 0) r[m_port[v]] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            mq[v].delete(); m_active[v] = 0; m_port[v] = 0;
        end
        for (int p = 0; p < NP; p++) begin
            m_cred[p] = DEPTH; m_rr[p] = 0;
        end
        m_ovf = 0; e_valid = 0; e_flit = '0; e_port = 0; e_vc = 0;
    endtask

    task automatic step();
        logic [NP-1:0] req_now;
        int gp, dv;
        bit ok;
        flit_t df;
        bit act_next [NV];
        req_now = model_req();
        gp = -1; dv = -1; ok = 0; df = '0;
        for (int p = NP - 1; p >= 0; p--) if (grants[p]) gp = p;
        if (gp >= 0) ok = req_now[gp];
        if (reset) begin
            model_reset();
        end else begin
            if (ok) begin
                for (int k = 0; k < NV; k++) begin
                    int v = (m_rr[gp] + k) % NV;
                    if (dv < 0 && m_active[v] && mq[v].size() > 0 && m_port[v] == gp) dv = v;
                end
            end
            for (int v = 0; v < NV; v++) begin
                act_next[v] = m_active[v];
                if (!m_active[v]) begin
                    if (mq[v].size() > 0) begin
                        if (mq[v][0].head) begin act_next[v] = 1; m_port[v] = mq[v][0].route; end
                    end else if (in_valid && in_vc == v && in_flit.head) begin
                        act_next[v] = 1; m_port[v] = in_flit.route;
                    end
                end
            end
            if (ok) begin
                df = mq[dv].pop_front();
                m_rr[gp] = (dv + 1) % NV;
                if (df.tail) act_next[dv] = 0;
            end
            if (in_valid) begin
                if (mq[in_vc].size() < DEPTH) mq[in_vc].push_back(in_flit);
                else m_ovf = 1;
            end
            for (int v = 0; v < NV; v++) m_active[v] = act_next[v];
            for (int p = 0; p < NP; p++) begin
                m_cred[p] = m_cred[p] - ((ok && gp == p) ? 1 : 0) + (credit_in[p] ? 1 : 0);
                if (m_cred[p] > DEPTH) m_cred[p] = DEPTH;
                if (m_cred[p] < 0) m_cred[p] = 0;
            end
            e_valid = ok;
            if (ok) begin e_flit = df; e_port = gp; e_vc = dv; end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc(bit iv, int vc, flit_t f, logic [NP-1:0] g, logic [NP-1:0] ci);
        in_valid = iv; in_vc = 1'(vc); in_flit = f; grants = g; credit_in = ci;
        step();
        in_valid = 0; grants = '0; credit_in = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        cyc(1, 0, mk(1, 1, 0, 32'hdead_beef), 4'b0001, 4'b0000);
        reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset();
        checks++; if (requests !== 4'b0000) begin errors++; $display("FAIL rst_requests got %b want 0000", requests); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (out_flit !== '0) begin errors++; $display("FAIL rst_out_flit got %h want 0", out_flit); end
        checks++; if (credit_out_valid !== 1'b0) begin errors++; $display("FAIL rst_credit_out_valid got %b want 0", credit_out_valid); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow_err); end
    endtask

    task automatic test_single_flit();
        do_reset();
        cyc(1, 0, mk(1, 1, 3, 32'h1111_0000), 4'b0000, 4'b0000);
        checks++; if (requests !== 4'b1000) begin errors++; $display("FAIL single_req got %b want 1000", requests); end
        cyc(0, 0, '0, 4'b1000, 4'b0000);
        checks++; if (out_valid !== 1'b1 || out_port !== 2'd3) begin errors++; $display("FAIL single_out got v=%b port=%0d want v=1 port=3", out_valid, out_port); end
        checks++; if (out_flit !== mk(1, 1, 3, 32'h1111_0000)) begin errors++; $display("FAIL single_flit got %h want %h", out_flit, mk(1, 1, 3, 32'h1111_0000)); end
        checks++; if (credit_out_valid !== 1'b1 || credit_out_vc !== 1'b0) begin errors++; $display("FAIL single_credit got v=%b vc=%0d want v=1 vc=0", credit_out_valid, credit_out_vc); end
        checks++; if (requests !== 4'b0000) begin errors++; $display("FAIL single_req_after got %b want 0000", requests); end
        cyc(0, 0, '0, 4'b0000, 4'b0000);
        checks++; if (out_valid !== 1'b0 || credit_out_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got v=%b cv=%b want 0 0", out_valid, credit_out_valid); end
    endtask

    task automatic test_rr_alternate();
        do_reset();
        for (int v = 0; v < NV; v++)
            for (int i = 0; i < 4; i++) cyc(1, v, mk(i == 0, i == 3, 1, 32'(v * 256 + i)), 4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, '0, 4'b0010, 4'b0000);
            checks++;
            if (out_valid !== 1'b1 || credit_out_vc !== 1'(i % 2) || out_flit.payload !== 32'((i % 2) * 256 + i / 2)) begin
                errors++;
                $display("FAIL rr_grant%0d got v=%b vc=%0d pl=%h want v=1 vc=%0d pl=%h", i, out_valid, credit_out_vc, out_flit.payload, i % 2, (i % 2) * 256 + i / 2);
            end
        end
    endtask

    task automatic test_credit_block();
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 0, mk(i == 0, i == 3, 2, 32'(16 + i)), 4'b0000, 4'b0000);
        for (int i = 0; i < 2; i++) cyc(1, 1, mk(i == 0, 0, 2, 32'(32 + i)), 4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, '0, 4'b0100, 4'b0000);
            checks++; if (out_valid !== 1'b1 || out_port !== 2'd2) begin errors++; $display("FAIL credit_grant%0d got v=%b port=%0d want v=1 port=2", i, out_valid, out_port); end
        end
        checks++; if (requests[2] !== 1'b0) begin errors++; $display("FAIL credit_zero got req2=%b want 0", requests[2]); end
        cyc(0, 0, '0, 4'b0000, 4'b0100);
        checks++; if (requests[2] !== 1'b1) begin errors++; $display("FAIL credit_return got req2=%b want 1", requests[2]); end
        cyc(0, 0, '0, 4'b0100, 4'b0000);
        checks++; if (out_valid !== 1'b1 || requests[2] !== 1'b0) begin errors++; $display("FAIL credit_reuse got v=%b req2=%b want 1 0", out_valid, requests[2]); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, mk(i == 0, 0, 0, 32'(i)), 4'b0000, 4'b0000);
            checks++; if (overflow_err !== (i == 4)) begin errors++; $display("FAIL ovf_write%0d got %b want %b", i, overflow_err, i == 4); end
        end
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 1, mk(i == 0, 0, 0, 32'(i)), 4'b0000, 4'b0000);
        cyc(1, 1, mk(0, 0, 0, 32'h44), 4'b0001, 4'b0000);
        checks++; if (overflow_err !== 1'b0 || out_valid !== 1'b1 || credit_out_vc !== 1'b1) begin errors++; $display("FAIL ovf_concurrent got ovf=%b v=%b vc=%0d want 0 1 1", overflow_err, out_valid, credit_out_vc); end
        cyc(1, 1, mk(0, 0, 0, 32'h55), 4'b0000, 4'b0000);
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_refull got %b want 1", overflow_err); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 0, mk(i == 0, i == 2, 0, 32'(64 + i)), 4'b0000, 4'b0000);
        cyc(0, 0, '0, 4'b0001, 4'b0000);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_first_deq got %b want 1", out_valid); end
        reset = 1;
        cyc(1, 0, mk(1, 0, 2, 32'h77), 4'b0001, 4'b1111);
        reset = 0;
        checks++;
        if (out_valid !== 1'b0 || out_flit !== '0 || credit_out_valid !== 1'b0 || requests !== 4'b0000 || overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got v=%b flit=%h cv=%b req=%b ovf=%b want 0 0 0 0000 0", out_valid, out_flit, credit_out_valid, requests, overflow_err);
        end
        cyc(0, 0, '0, 4'b0000, 4'b0000);
        checks++; if (requests !== 4'b0000) begin errors++; $display("FAIL mid_ignored_write got req=%b want 0000", requests); end
        for (int i = 0; i < 4; i++) cyc(1, 0, mk(i == 0, i == 3, 0, 32'(128 + i)), 4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, '0, 4'b0001, 4'b0000);
            checks++; if (out_valid !== 1'b1 || out_flit.payload !== 32'(128 + i)) begin errors++; $display("FAIL mid_refill%0d got v=%b pl=%h want 1 %h", i, out_valid, out_flit.payload, 128 + i); end
        end
    endtask

    task automatic test_multi_grant();
        do_reset();
        cyc(1, 0, mk(1, 0, 1, 32'hA0), 4'b0000, 4'b0000);
        cyc(1, 0, mk(0, 1, 1, 32'hA1), 4'b0000, 4'b0000);
        cyc(1, 1, mk(1, 0, 2, 32'hB0), 4'b0000, 4'b0000);
        cyc(1, 1, mk(0, 1, 2, 32'hB1), 4'b0000, 4'b0000);
        checks++; if (requests !== 4'b0110) begin errors++; $display("FAIL multi_req got %b want 0110", requests); end
        cyc(0, 0, '0, 4'b0110, 4'b0000);
        checks++; if (out_valid !== 1'b1 || out_port !== 2'd1 || out_flit.payload !== 32'hA0) begin errors++; $display("FAIL multi_lowest got v=%b port=%0d pl=%h want 1 1 a0", out_valid, out_port, out_flit.payload); end
        cyc(0, 0, '0, 4'b1000, 4'b0000);
        checks++; if (out_valid !== 1'b0 || requests !== 4'b0110) begin errors++; $display("FAIL multi_unrequested got v=%b req=%b want 0 0110", out_valid, requests); end
    endtask

    task automatic test_random();
        bit in_pkt [NV];
        bit iv;
        int vc;
        flit_t f;
        logic [NP-1:0] g, ci, rq;
        for (int n = 0; n < 1200; n++) begin
            if (n % 600 == 0) begin
                do_reset();
                for (int v = 0; v < NV; v++) in_pkt[v] = 0;
            end
            iv = ($urandom_range(0, 1) == 1);
            vc = $urandom_range(0, NV - 1);
            if (mq[vc].size() >= DEPTH && $urandom_range(0, 9) != 0) iv = 0;
            f = mk(!in_pkt[vc], $urandom_range(0, 3) == 0, $urandom_range(0, NP - 1), $urandom);
            if (iv) in_pkt[vc] = !f.tail;
            rq = model_req();
            g = '0;
            case ($urandom_range(0, 4))
                0, 1, 2: for (int t = 0; t < 8; t++) begin
                    int p = $urandom_range(0, NP - 1);
                    if (rq[p]) begin g = 4'b0001 << p; break; end
                end
                3: g = 4'($urandom);
                default: g = '0;
            endcase
            for (int p = 0; p < NP; p++) ci[p] = ($urandom_range(0, 4) == 0);
            cyc(iv, vc, f, g, ci);
            checks++; if (out_valid !== e_valid || credit_out_valid !== e_valid) begin errors++; $display("FAIL rnd_valid n=%0d got v=%b cv=%b want %b", n, out_valid, credit_out_valid, e_valid); end
            if (e_valid) begin
                checks++;
                if (out_flit !== e_flit || out_port !== 2'(e_port) || credit_out_vc !== 1'(e_vc)) begin
                    errors++;
                    $display("FAIL rnd_flit n=%0d got %h/%0d/%0d want %h/%0d/%0d", n, out_flit, out_port, credit_out_vc, e_flit, e_port, e_vc);
                end
            end
            checks++; if (requests !== model_req()) begin errors++; $display("FAIL rnd_requests n=%0d got %b want %b", n, requests, model_req()); end
            checks++; if (overflow_err !== m_ovf) begin errors++; $display("FAIL rnd_overflow n=%0d got %b want %b", n, overflow_err, m_ovf); end
        end
    endtask

    initial begin
        reset = 1; in_valid = 0; in_vc = '0; in_flit = '0; grants = '0; credit_in = '0;
        model_reset();
        test_reset();
        test_single_flit();
        test_rr_alternate();
        test_credit_block();
        test_overflow();
        test_reset_mid_packet();
        test_multi_grant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
